// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: instruction fetch with in-order imem requests, prefetch queue and redirect flush
module if_prefetch_stage #(
  parameter int XLEN = 32,
  parameter int FETCH_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   pc_src,
  input  logic [XLEN-1:0]              branch_addr,
  input  logic [XLEN-1:0]              jump_addr,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [XLEN-1:0]              imem_addr,
  input  logic                         imem_rsp_valid,
  input  logic [XLEN-1:0]              imem_rsp_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_instr,
  output logic [XLEN-1:0]              out_pc,
  output logic [XLEN-1:0]              out_pc_plus4,
  output logic [$clog2(FETCH_DEPTH):0] occupancy
);
  localparam int PW = $clog2(FETCH_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FETCH_DEPTH);
  logic [XLEN-1:0] instr_mem [FETCH_DEPTH];
  logic [XLEN-1:0] pc_mem [FETCH_DEPTH];
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
  logic            redirect, req_hs, push, pop, drop_rsp;
  // Next-state logic; a redirect flushes the queue and marks every in-flight fetch as stale
  always_comb begin
    redirect       = pc_src == 2'd1 || pc_src == 2'd2;
    target         = pc_src == 2'd1 ? {branch_addr[XLEN-1:2], 2'b00} : {jump_addr[XLEN-1:2], 2'b00};
    imem_req_valid = !rst && !redirect && ({1'b0, cnt_q} + {1'b0, out_q} < DEPTH_W);
    req_hs         = imem_req_valid && imem_req_ready;
    drop_rsp       = imem_rsp_valid && drop_q != '0;
    push           = imem_rsp_valid && drop_q == '0 && !redirect;
    pop            = out_valid && out_ready && !redirect;
    out_d          = out_q + CW'(req_hs) - CW'(imem_rsp_valid);
    drop_d         = redirect ? out_q - CW'(imem_rsp_valid) : drop_q - CW'(drop_rsp);
    cnt_d          = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
    rd_d           = redirect ? '0 : rd_q + PW'(pop);
    wr_d           = redirect ? '0 : wr_q + PW'(push);
    fetch_pc_d     = redirect ? target : fetch_pc_q + (req_hs ? XLEN'(4) : '0);
    rsp_pc_d       = redirect ? target : rsp_pc_q + (push ? XLEN'(4) : '0);
    imem_addr      = fetch_pc_q;
    out_valid      = cnt_q != '0;
    out_instr      = out_valid ? instr_mem[rd_q] : '0;
    out_pc         = out_valid ? pc_mem[rd_q] : '0;
    out_pc_plus4   = out_pc + XLEN'(4);
    occupancy      = cnt_q;
  end
  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end
  // Queue storage; contents are only meaningful below cnt_q so no reset is needed
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instr_mem[wr_q] <= imem_rsp_data;
      pc_mem[wr_q]    <= rsp_pc_q;
    end
  end
endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb_if_prefetch_stage: vector table, directed corner sequences and random run against a queue model
module tb_if_prefetch_stage;
  localparam int D = 4;
  localparam logic [31:0] RPC = 32'h0;
  logic        clk, rst;
  logic [1:0]  pc_src;
  logic [31:0] branch_addr, jump_addr, imem_addr, imem_rsp_data;
  logic [31:0] out_instr, out_pc, out_pc_plus4;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, out_valid, out_ready;
  logic [2:0]  occupancy;

  if_prefetch_stage #(.XLEN(32), .FETCH_DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .branch_addr(branch_addr), .jump_addr(jump_addr),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .occupancy(occupancy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] ba, ja;
    logic        rr, rv;
    logic [31:0] rd;
    logic        ordy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc, e_ins;
    logic [2:0]  e_occ;
  } vec_t;
  typedef struct { logic [31:0] pc, ins; } ent_t;
  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;

  int checks = 0, errors = 0;
  ent_t eq[$];
  req_t mq[$];
  logic [31:0] mpc;
  int lat = 1;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return ~a ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", n, cyc, a, e);
    end
  endtask

  // Drives one cycle at a negedge, checks against the model, advances the model, waits for next negedge
  task automatic step(input logic [1:0] src, input logic [31:0] ba, input logic [31:0] ja,
                      input logic rr, input logic ordy);
    bit redir, e_rv, rsp;
    req_t r;
    pc_src = src; branch_addr = ba; jump_addr = ja; imem_req_ready = rr; out_ready = ordy;
    rsp = mq.size() > 0 && mq[0].due <= cyc;
    imem_rsp_valid = rsp;
    imem_rsp_data = rsp ? dat(mq[0].addr) : $urandom;
    #1;
    redir = src == 2'd1 || src == 2'd2;
    e_rv = !redir && (eq.size() + mq.size() < D);
    chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
    chk("imem_addr", imem_addr, mpc);
    chk("out_valid", 32'(out_valid), 32'(eq.size() > 0));
    chk("occupancy", 32'(occupancy), eq.size());
    if (eq.size() > 0) begin
      chk("out_pc", out_pc, eq[0].pc);
      chk("out_instr", out_instr, eq[0].ins);
      chk("out_pc_plus4", out_pc_plus4, eq[0].pc + 32'd4);
    end
    if (rsp) r = mq.pop_front();
    if (redir) begin
      eq.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
      mpc = (src == 2'd1 ? ba : ja) & ~32'h3;
    end else begin
      if (eq.size() > 0 && ordy) void'(eq.pop_front());
      if (rsp && !r.stale) eq.push_back('{r.addr, dat(r.addr)});
      if (e_rv && rr) begin
        mq.push_back('{mpc, cyc + lat, 1'b0});
        mpc += 32'd4;
      end
    end
    @(negedge clk);
  endtask

  // Two reset cycles with a stray response and a redirect request, both of which must be ignored
  task automatic do_reset();
    rst = 1; pc_src = 2'd1; branch_addr = $urandom; jump_addr = $urandom;
    imem_rsp_valid = 1; imem_rsp_data = $urandom; imem_req_ready = 1; out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_imem_addr", imem_addr, RPC);
    rst = 0; pc_src = 2'd0; imem_rsp_valid = 0;
    eq.delete(); mq.delete(); mpc = RPC;
  endtask

  vec_t tbl[11];

  initial begin
    rst = 1; pc_src = 0; branch_addr = 0; jump_addr = 0; imem_req_ready = 0;
    imem_rsp_valid = 0; imem_rsp_data = 0; out_ready = 0;
    tbl[0]  = '{2'd0, 32'h0,   32'h0,   1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h000, 1'b0, 32'h0,   32'h0,        3'd0};
    tbl[1]  = '{2'd0, 32'h0,   32'h0,   1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h004, 1'b0, 32'h0,   32'h0,        3'd0};
    tbl[2]  = '{2'd0, 32'h0,   32'h0,   1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b1, 32'h008, 1'b1, 32'h0,   32'h1111_1111, 3'd1};
    tbl[3]  = '{2'd0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00C, 1'b1, 32'h4,   32'h2222_2222, 3'd1};
    tbl[4]  = '{2'd1, 32'h105, 32'h0,   1'b1, 1'b1, 32'h3333_3333, 1'b1, 1'b0, 32'h00C, 1'b1, 32'h4,   32'h2222_2222, 3'd1};
    tbl[5]  = '{2'd0, 32'h0,   32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   32'h0,        3'd0};
    tbl[6]  = '{2'd2, 32'h0,   32'h203, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h108, 1'b0, 32'h0,   32'h0,        3'd0};
    tbl[7]  = '{2'd0, 32'h0,   32'h0,   1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h0,        3'd0};
    tbl[8]  = '{2'd0, 32'h0,   32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h0,        3'd0};
    tbl[9]  = '{2'd3, 32'h0,   32'h0,   1'b0, 1'b1, 32'h4444_4444, 1'b0, 1'b1, 32'h204, 1'b0, 32'h0,   32'h0,        3'd0};
    tbl[10] = '{2'd0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h204, 1'b1, 32'h200, 32'h4444_4444, 3'd1};
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 11; i++) begin
      pc_src = tbl[i].src; branch_addr = tbl[i].ba; jump_addr = tbl[i].ja;
      imem_req_ready = tbl[i].rr; imem_rsp_valid = tbl[i].rv; imem_rsp_data = tbl[i].rd;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_rv));
      chk($sformatf("vec%0d_imem_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
      if (tbl[i].e_ov) begin
        chk($sformatf("vec%0d_out_pc", i), out_pc, tbl[i].e_pc);
        chk($sformatf("vec%0d_out_instr", i), out_instr, tbl[i].e_ins);
        chk($sformatf("vec%0d_pc_plus4", i), out_pc_plus4, tbl[i].e_pc + 32'd4);
      end
      @(negedge clk);
    end
    do_reset();
    lat = 1;
    for (int i = 0; i < 12; i++) step(2'd0, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(2'd0, 0, 0, 1'b1, 1'b0);
    chk("stall_occupancy", 32'(occupancy), 32'd4);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < 8; i++) step(2'd0, 0, 0, 1'b1, 1'b1);
    do_reset();
    lat = 3;
    for (int i = 0; i < 3; i++) step(2'd0, 0, 0, 1'b1, 1'b1);
    step(2'd1, 32'h100, 0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(2'd0, 0, 0, 1'b1, 1'b0);
    chk("branch_first_pc", out_pc, 32'h100);
    for (int i = 0; i < 6; i++) step(2'd0, 0, 0, 1'b1, 1'b1);
    lat = 1;
    for (int i = 0; i < 4; i++) step(2'd0, 0, 0, 1'b1, 1'b1);
    step(2'd2, 0, 32'h203, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(2'd0, 0, 0, 1'b1, 1'b1);
    step(2'd2, 0, 32'hFFFF_FFFC, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(2'd3, 0, 0, 1'b1, 1'b1);
    lat = 3;
    for (int i = 0; i < 6; i++) step(2'd0, 0, 0, 1'b1, 1'b0);
    do_reset();
    step(2'd0, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      int s;
      logic [1:0] src;
      s = $urandom_range(0, 15);
      src = s < 12 ? 2'd0 : s == 12 ? 2'd1 : s == 13 ? 2'd2 : 2'd3;
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 499) == 0) do_reset();
      step(src, $urandom, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
